aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Sequencing controller for the iterative AES-128 round datapath. It accepts a block-start handshake and drives the datapath's `round` select, the round-key index to the key store and `output_enable`. It then pulses `done` when the ciphertext is valid on the datapath output. It sits between the host/DMA front end and the round datapath, alongside the round-key store, inside the AES core top level.

## Interface
- `NR`, default 10: number of rounds; legal values are 10, 12 or 14.
- `KW`, default 4: width of `key_idx`; must satisfy `NR < 2**KW`.
- `BCW`, default 32: width of `block_cnt`.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `key_ready`  in  1  the key store holds a valid expanded key schedule.
- `start`  in  1  request to encrypt the block currently on datapath `datain`.
- `in_ready`  out  1  a start is accepted on an edge where `start && in_ready`.
- `round`  out  2  datapath input-mux select: 2'b00 INITIAL, 2'b01 INTERMEDIATE, 2'b10 LAST. 2'b11 is never driven.
- `key_idx`  out  KW  index of the round key the key store must present this cycle.
- `output_enable`  out  1  datapath output gate.
- `done`  out  1  one-cycle pulse; ciphertext is valid on datapath `dataout` in this cycle.
- `busy`  out  1  a block is in flight, or is completing in this cycle.
- `block_cnt`  out  BCW  count of completed blocks.

## Operation
- The state machine has three states: IDLE, ROUND (with counter `cnt` in 0..NR-1) and FINAL.
- IDLE:
  - Outputs: `round`=INITIAL (the datapath register continuously samples `datain`), `key_idx`=0, `output_enable`=0, `busy`=0.
  - Transition: on accept, go to ROUND with `cnt`=0.
- ROUND:
  - Outputs: `key_idx`=`cnt`.
  - `round`=LAST when `cnt`==NR-1, otherwise INTERMEDIATE.
  - `busy`=1.
  - Transition: `cnt` increments each cycle; when `cnt`==NR-1, go to FINAL.
- FINAL:
  - Outputs: `key_idx`=NR, `output_enable`=1, `done`=1, `busy`=1, `round`=INITIAL.
  - Transition: on accept, go to ROUND with `cnt`=0 (back-to-back); otherwise go to IDLE.
  - `block_cnt` increments on the edge leaving FINAL and wraps modulo 2**BCW.
- `in_ready` = `key_ready && (state==IDLE || state==FINAL)`.
- `start` is ignored whenever `in_ready`=0. There is no queueing.
- A deassertion of `key_ready` mid-block has no effect on sequencing. The key store must keep the schedule stable until `done`.
- All outputs except `in_ready` are decoded from registered state only. There is no input-to-output combinational path other than `key_ready` to `in_ready`.

## Timing
- Reset values: state IDLE, `cnt`=0, `round`=2'b00, `key_idx`=0, `output_enable`=0, `done`=0, `busy`=0, `block_cnt`=0, `in_ready`=`key_ready`.
- Accept edge E0: the datapath register captures `datain`. In the cycle after E0, `key_idx`=0, so `dataout` = `datain` ^ K0.
- Edge Ek (k=1..NR): the register captures the round-k pre-key state. `key_idx`=k in the following cycle.
- Latency: `done` is high in the cycle beginning at edge E0+NR (10 cycles after accept for NR=10).
- Throughput: one block every NR+1 cycles when `start` is held high.
- `rst` asserted in any state, including mid-block: the next edge forces the reset values. The partial block is discarded with no `done`.
- `rst` and `start` in the same cycle: `rst` wins and the start is not accepted.
- `start` in FINAL with `key_ready`=0: not accepted; go to IDLE.

## Structure
- Shared package `aes_pkg` holds:
  - round encodings `ROUND_INITIAL`, `ROUND_INTERMEDIATE`, `ROUND_LAST`;
  - the controller state enum;
  - `NR_AES128/192/256` constants.
- The block is a single module with no sub-modules.
- The AES core top level instantiates this controller, the round datapath and the key store, wiring `key_idx` to the key store and `round`/`output_enable` to the datapath.

## Test plan
- Reset then idle with `key_ready`=1: `in_ready`=1, `round`=00, `output_enable`=0, `block_cnt`=0.
- Single block, integrated core, FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff.
  - `done` is high exactly 10 cycles after accept.
  - `dataout` = 69c4e0d86a7b0430d8cdb78070b4c55a in that cycle and 0 in all other cycles.
  - `key_idx` sequence is 0..10.
- Back-to-back: `start` held high for 3 blocks.
  - Accepts occur at cycles 0, 11 and 22.
  - `done` occurs at cycles 10, 21 and 32.
  - `block_cnt` reads 3 afterwards.
  - `round` pattern per block is 01×9, 10, 00.
- Gating: `key_ready`=0 with `start`=1 gives no accept and `busy` stays 0. Dropping `key_ready` mid-block does not disturb the sequence.
- Mid-block reset:
  - `rst` asserted at cycle 5 after accept: all outputs return to reset values on the next edge and no `done` is produced.
  - A subsequent block produces the correct ciphertext.
- Corner cases:
  - `rst` and `start` together: no accept.
  - NR=14 build: `done` 14 cycles after accept, `key_idx` reaches 14.
  - `block_cnt` wraps from 2**BCW−1 to 0 (force BCW=4 and run 16 blocks).

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES core definitions: round-mux encodings, controller states and
// round counts per key size.
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int NR_AES192 = 12;
  localparam int NR_AES256 = 14;

  localparam logic [1:0] ROUND_INITIAL      = 2'b00;
  localparam logic [1:0] ROUND_INTERMEDIATE = 2'b01;
  localparam logic [1:0] ROUND_LAST         = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ROUND = 2'b01,
    ST_FINAL = 2'b10
  } ctrl_state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES round datapath: steps the round-mux select
// and round-key index, gates the output and pulses done per block.
//
// state | meaning
// IDLE  | datapath samples datain, waiting for an accepted start
// ROUND | round cnt in 0..NR-1 in flight, key_idx = cnt
// FINAL | ciphertext valid, done pulse; may accept the next block
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR  = NR_AES128,
  parameter int KW  = 4,
  parameter int BCW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_ready,
  input  logic           start,
  output logic           in_ready,
  output logic [1:0]     round,
  output logic [KW-1:0]  key_idx,
  output logic           output_enable,
  output logic           done,
  output logic           busy,
  output logic [BCW-1:0] block_cnt
);

  localparam logic [KW-1:0] LP_CNT_LAST = KW'(NR - 1);
  localparam logic [KW-1:0] LP_KEY_LAST = KW'(NR);

  ctrl_state_e    r_state;
  logic [KW-1:0]  r_cnt;
  logic [BCW-1:0] r_block_cnt;

  ctrl_state_e    w_next_state;
  logic [KW-1:0]  w_next_cnt;
  logic           w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_block_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (r_state == ST_FINAL) begin
        r_block_cnt <= r_block_cnt + BCW'(1);
      end
    end
  end

  // in_ready is the only output allowed to see an input combinationally.
  always_comb begin
    in_ready = key_ready && ((r_state == ST_IDLE) || (r_state == ST_FINAL));
    w_accept = start && in_ready;
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = ST_ROUND;
          w_next_cnt   = '0;
        end
      end
      ST_ROUND: begin
        if (r_cnt == LP_CNT_LAST) begin
          w_next_state = ST_FINAL;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + KW'(1);
        end
      end
      ST_FINAL: begin
        w_next_cnt   = '0;
        w_next_state = w_accept ? ST_ROUND : ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    round         = ROUND_INITIAL;
    key_idx       = '0;
    output_enable = 1'b0;
    done          = 1'b0;
    busy          = 1'b0;
    case (r_state)
      ST_ROUND: begin
        key_idx = r_cnt;
        round   = (r_cnt == LP_CNT_LAST) ? ROUND_LAST : ROUND_INTERMEDIATE;
        busy    = 1'b1;
      end
      ST_FINAL: begin
        key_idx       = LP_KEY_LAST;
        output_enable = 1'b1;
        done          = 1'b1;
        busy          = 1'b1;
      end
      default: ;
    endcase
  end

  assign block_cnt = r_block_cnt;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench: an AES-128 controller and an NR=14/BCW=4 build, each
// checked every cycle against a cycles-since-accept model.
module tb_aes_round_ctrl;

  localparam int NR0 = 10;
  localparam int NR1 = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, kr0, start0, rst1, kr1, start1;
  logic in_ready0, oe0, done0, busy0, in_ready1, oe1, done1, busy1;
  logic [1:0]  round0, round1;
  logic [3:0]  key_idx0, key_idx1;
  logic [31:0] block_cnt0;
  logic [3:0]  block_cnt1;

  aes_round_ctrl #(.NR(NR0), .KW(4), .BCW(32)) u_dut0 (
    .clk(clk), .rst(rst0), .key_ready(kr0), .start(start0),
    .in_ready(in_ready0), .round(round0), .key_idx(key_idx0),
    .output_enable(oe0), .done(done0), .busy(busy0), .block_cnt(block_cnt0)
  );

  aes_round_ctrl #(.NR(NR1), .KW(4), .BCW(4)) u_dut1 (
    .clk(clk), .rst(rst1), .key_ready(kr1), .start(start1),
    .in_ready(in_ready1), .round(round1), .key_idx(key_idx1),
    .output_enable(oe1), .done(done1), .busy(busy1), .block_cnt(block_cnt1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // t = edges since the last accept (0 when no block is in flight).
  function automatic void model_out(input int t, input int nr, input bit kr,
                                    output int irdy, output int rnd, output int kidx,
                                    output int oe, output int dn, output int bsy);
    irdy = 0; rnd = 0; kidx = 0; oe = 0; dn = 0; bsy = 0;
    if (t == 0) begin
      irdy = kr;
    end else if (t <= nr) begin
      rnd  = (t == nr) ? 2 : 1;
      kidx = t - 1;
      bsy  = 1;
    end else begin
      irdy = kr; kidx = nr; oe = 1; dn = 1; bsy = 1;
    end
  endfunction

  int m0_t = 0, m1_t = 0;
  longint m0_blk = 0, m1_blk = 0;
  int acc_q0[$], acc_q1[$], done_q0[$], done_q1[$];
  int kidx_log0[$], kidx_log1[$], rnd_log0[$];
  bit acc0, acc1, saw15;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rst0) begin
      m0_t = 0; m0_blk = 0;
    end else begin
      acc0 = start0 && kr0 && (m0_t == 0 || m0_t == NR0 + 1);
      if (m0_t == NR0 + 1) m0_blk = (m0_blk + 1) % 64'h1_0000_0000;
      if (acc0) begin m0_t = 1; acc_q0.push_back(cyc); end
      else if (m0_t == NR0 + 1) m0_t = 0;
      else if (m0_t > 0) m0_t++;
    end
    if (rst1) begin
      m1_t = 0; m1_blk = 0;
    end else begin
      acc1 = start1 && kr1 && (m1_t == 0 || m1_t == NR1 + 1);
      if (m1_t == NR1 + 1) m1_blk = (m1_blk + 1) % 16;
      if (acc1) begin m1_t = 1; acc_q1.push_back(cyc); end
      else if (m1_t == NR1 + 1) m1_t = 0;
      else if (m1_t > 0) m1_t++;
    end
  end

  always @(negedge clk) begin
    int irdy, rnd, kidx, oe, dn, bsy;
    if (chk_en) begin
      model_out(m0_t, NR0, kr0, irdy, rnd, kidx, oe, dn, bsy);
      chk("d0.in_ready", in_ready0, irdy);
      chk("d0.round", round0, rnd);
      chk("d0.key_idx", key_idx0, kidx);
      chk("d0.output_enable", oe0, oe);
      chk("d0.done", done0, dn);
      chk("d0.busy", busy0, bsy);
      chk("d0.block_cnt", block_cnt0, m0_blk);
      model_out(m1_t, NR1, kr1, irdy, rnd, kidx, oe, dn, bsy);
      chk("d1.in_ready", in_ready1, irdy);
      chk("d1.round", round1, rnd);
      chk("d1.key_idx", key_idx1, kidx);
      chk("d1.output_enable", oe1, oe);
      chk("d1.done", done1, dn);
      chk("d1.busy", busy1, bsy);
      chk("d1.block_cnt", block_cnt1, m1_blk);
      // done is labelled by the edge that starts its cycle
      if (done0) done_q0.push_back(cyc - 1);
      if (done1) done_q1.push_back(cyc - 1);
      if (busy0) begin kidx_log0.push_back(key_idx0); rnd_log0.push_back(round0); end
      if (busy1) kidx_log1.push_back(key_idx1);
      if (block_cnt1 == 4'd15) saw15 = 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs();
    acc_q0.delete(); done_q0.delete(); kidx_log0.delete(); rnd_log0.delete();
    acc_q1.delete(); done_q1.delete(); kidx_log1.delete();
  endtask

  task automatic check_block_rounds(input string name, input int base);
    int exp_rnd;
    for (int i = 0; i < 11; i++) begin
      exp_rnd = (i < 9) ? 1 : (i == 9) ? 2 : 0;
      chk(name, (base + i < rnd_log0.size()) ? rnd_log0[base + i] : -1, exp_rnd);
    end
  endtask

  initial begin
    rst0 = 1; kr0 = 1; start0 = 0;
    rst1 = 1; kr1 = 1; start1 = 0;
    saw15 = 0;
    tick(1);
    chk_en = 1;
    tick(1);
    rst0 = 0; rst1 = 0;
    tick(3);

    // reset / idle
    chk("idle.in_ready", in_ready0, 1);
    chk("idle.round", round0, 0);
    chk("idle.oe", oe0, 0);
    chk("idle.block_cnt", block_cnt0, 0);

    // single block
    clear_logs();
    start0 = 1; tick(1); start0 = 0;
    tick(14);
    chk("single.accepts", acc_q0.size(), 1);
    chk("single.dones", done_q0.size(), 1);
    if (acc_q0.size() == 1 && done_q0.size() == 1)
      chk("single.latency", done_q0[0] - acc_q0[0], 10);
    chk("single.kidx_len", kidx_log0.size(), 11);
    for (int i = 0; i < kidx_log0.size() && i < 11; i++) chk("single.kidx_seq", kidx_log0[i], i);
    check_block_rounds("single.round_seq", 0);
    chk("single.block_cnt", block_cnt0, 1);

    // back-to-back, three blocks
    rst0 = 1; tick(1); rst0 = 0;
    clear_logs();
    start0 = 1;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (acc_q0.size() >= 3) break;
    end
    start0 = 0;
    tick(15);
    chk("b2b.accepts", acc_q0.size(), 3);
    chk("b2b.dones", done_q0.size(), 3);
    if (acc_q0.size() == 3 && done_q0.size() == 3) begin
      chk("b2b.acc1", acc_q0[1] - acc_q0[0], 11);
      chk("b2b.acc2", acc_q0[2] - acc_q0[0], 22);
      chk("b2b.done0", done_q0[0] - acc_q0[0], 10);
      chk("b2b.done1", done_q0[1] - acc_q0[0], 21);
      chk("b2b.done2", done_q0[2] - acc_q0[0], 32);
    end
    chk("b2b.block_cnt", block_cnt0, 3);
    for (int b = 0; b < 3; b++) check_block_rounds("b2b.round_seq", b * 11);

    // key_ready gating, then key_ready dropped mid-block
    clear_logs();
    kr0 = 0; start0 = 1;
    for (int i = 0; i < 5; i++) begin tick(1); chk("gate.busy", busy0, 0); end
    chk("gate.accepts", acc_q0.size(), 0);
    kr0 = 1; tick(1); start0 = 0;
    tick(3); kr0 = 0; tick(4); kr0 = 1;
    tick(8);
    chk("kdrop.dones", done_q0.size(), 1);
    if (acc_q0.size() == 1 && done_q0.size() == 1)
      chk("kdrop.latency", done_q0[0] - acc_q0[0], 10);
    chk("kdrop.block_cnt", block_cnt0, 4);

    // mid-block reset, rst+start together, then a clean block
    clear_logs();
    start0 = 1; tick(1); start0 = 0;
    tick(4);
    rst0 = 1; tick(1); rst0 = 0;
    chk("midrst.busy", busy0, 0);
    chk("midrst.key_idx", key_idx0, 0);
    chk("midrst.block_cnt", block_cnt0, 0);
    tick(12);
    chk("midrst.no_done", done_q0.size(), 0);
    rst0 = 1; start0 = 1; tick(1); rst0 = 0; start0 = 0;
    tick(1);
    chk("rststart.busy", busy0, 0);
    chk("rststart.accepts", acc_q0.size(), 1);
    start0 = 1; tick(1); start0 = 0;
    tick(14);
    chk("after_rst.dones", done_q0.size(), 1);
    if (acc_q0.size() == 2 && done_q0.size() == 1)
      chk("after_rst.latency", done_q0[0] - acc_q0[1], 10);

    // NR=14 build, single block
    clear_logs();
    start1 = 1; tick(1); start1 = 0;
    tick(18);
    chk("nr14.dones", done_q1.size(), 1);
    if (acc_q1.size() == 1 && done_q1.size() == 1)
      chk("nr14.latency", done_q1[0] - acc_q1[0], 14);
    chk("nr14.kidx_len", kidx_log1.size(), 15);
    if (kidx_log1.size() > 0) chk("nr14.kidx_last", kidx_log1[kidx_log1.size() - 1], 14);

    // BCW=4 wrap over 16 blocks
    rst1 = 1; tick(1); rst1 = 0;
    clear_logs();
    saw15 = 0;
    start1 = 1;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (acc_q1.size() >= 16) break;
    end
    start1 = 0;
    tick(18);
    chk("wrap.dones", done_q1.size(), 16);
    chk("wrap.saw15", saw15, 1);
    chk("wrap.block_cnt", block_cnt1, 0);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
